// File: rtl/coreresetp_sdif_rst_seq.sv
// Sequenced release of up to four SDIF blocks: PHY reset first, then core reset once the
// SDIF reports ready for a programmable delay, with timeout detection and hot-reset gating.
module coreresetp_sdif_rst_seq #(
   parameter int unsigned TIMEOUT     = 1000,
   parameter int unsigned RELEASE_DLY = 16
) (
   input  logic       CLK_BASE,
   input  logic       RESET,
   input  logic       START,
   input  logic [3:0] SDIF_EN,
   input  logic [3:0] SDIF_READY,
   input  logic [3:0] HOT_REQ,
   output logic [3:0] SDIF_PHY_RESET_N,
   output logic [3:0] SDIF_CORE_RESET_N,
   output logic       DONE,
   output logic       TIMEOUT_ERR,
   output logic [1:0] ERR_IDX
);

   localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);
   localparam logic [15:0] REL_LAST = 16'(RELEASE_DLY - 1);

   typedef enum logic [2:0] {
      IDLE,
      SEL,
      WAIT_READY,
      CORE_DLY,
      NEXT,
      DONE_ST,
      ERR
   } state_t;

   state_t      state, state_nxt;
   logic [1:0]  idx, idx_nxt;
   logic [15:0] cnt, cnt_nxt;
   logic [3:0]  phy_rel, phy_nxt;
   logic [3:0]  core_rel, core_nxt;
   logic        start_q;
   logic        start_armed;
   logic        start_edge;
   logic [3:0]  ready_p0;
   logic [3:0]  ready_s;
   logic [3:0]  core_n_q;
   logic        done_q;
   logic        terr_q;
   logic [1:0]  err_idx_q;

   // SDIF_READY crosses into CLK_BASE through two flops
   always_ff @(posedge CLK_BASE or posedge RESET) begin
      if (RESET) begin
         ready_p0 <= 4'b0000;
         ready_s  <= 4'b0000;
      end else begin
         ready_p0 <= SDIF_READY;
         ready_s  <= ready_p0;
      end
   end

   // start_armed blocks a START that was already high when reset released
   always_ff @(posedge CLK_BASE or posedge RESET) begin
      if (RESET) begin
         start_q     <= 1'b0;
         start_armed <= 1'b0;
      end else begin
         start_q <= START;
         if (!START) begin
            start_armed <= 1'b1;
         end
      end
   end

   assign start_edge = START & ~start_q & start_armed;

   always_ff @(posedge CLK_BASE or posedge RESET) begin
      if (RESET) begin
         state    <= IDLE;
         idx      <= 2'd0;
         cnt      <= 16'd0;
         phy_rel  <= 4'b0000;
         core_rel <= 4'b0000;
      end else begin
         state    <= state_nxt;
         idx      <= idx_nxt;
         cnt      <= cnt_nxt;
         phy_rel  <= phy_nxt;
         core_rel <= core_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      idx_nxt   = idx;
      cnt_nxt   = cnt;
      phy_nxt   = phy_rel;
      core_nxt  = core_rel;
      case (state)
         IDLE: begin
            if (start_edge) begin
               state_nxt = SEL;
               idx_nxt   = 2'd0;
               cnt_nxt   = 16'd0;
            end
         end
         SEL: begin
            if (!SDIF_EN[idx]) begin
               state_nxt = NEXT;
            end else begin
               phy_nxt[idx] = 1'b1;
               cnt_nxt      = 16'd0;
               state_nxt    = WAIT_READY;
            end
         end
         WAIT_READY: begin
            if (ready_s[idx]) begin
               cnt_nxt   = 16'd0;
               state_nxt = CORE_DLY;
            end else if (cnt == TMO_LAST) begin
               state_nxt = ERR;
            end else begin
               cnt_nxt = cnt + 16'd1;
            end
         end
         CORE_DLY: begin
            // a ready drop restarts the whole wait, including a fresh timeout window
            if (!ready_s[idx]) begin
               cnt_nxt   = 16'd0;
               state_nxt = WAIT_READY;
            end else if (cnt == REL_LAST) begin
               core_nxt[idx] = 1'b1;
               state_nxt     = NEXT;
            end else begin
               cnt_nxt = cnt + 16'd1;
            end
         end
         NEXT: begin
            if (idx == 2'd3) begin
               state_nxt = DONE_ST;
            end else begin
               idx_nxt   = idx + 2'd1;
               state_nxt = SEL;
            end
         end
         DONE_ST, ERR: begin
            if (start_edge) begin
               state_nxt = SEL;
               idx_nxt   = 2'd0;
               cnt_nxt   = 16'd0;
               phy_nxt   = 4'b0000;
               core_nxt  = 4'b0000;
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // status and core outputs load from next-state values so they change with the FSM
   always_ff @(posedge CLK_BASE or posedge RESET) begin
      if (RESET) begin
         core_n_q  <= 4'b0000;
         done_q    <= 1'b0;
         terr_q    <= 1'b0;
         err_idx_q <= 2'b00;
      end else begin
         core_n_q  <= core_nxt & ~HOT_REQ;
         done_q    <= (state_nxt == DONE_ST);
         terr_q    <= (state_nxt == ERR);
         err_idx_q <= (state_nxt == ERR) ? idx_nxt : 2'b00;
      end
   end

   assign SDIF_PHY_RESET_N  = phy_rel;
   assign SDIF_CORE_RESET_N = core_n_q;
   assign DONE              = done_q;
   assign TIMEOUT_ERR       = terr_q;
   assign ERR_IDX           = err_idx_q;

endmodule

// File: tb/tb_coreresetp_sdif_rst_seq.sv
// Scoreboard bench for coreresetp_sdif_rst_seq: stimulus queues expected output snapshots,
// a monitor pops one on every output change and checks value and cycle spacing.
module tb_coreresetp_sdif_rst_seq;

   logic       CLK_BASE;
   logic       RESET;
   logic       START;
   logic [3:0] SDIF_EN;
   logic [3:0] SDIF_READY;
   logic [3:0] HOT_REQ;
   logic [3:0] SDIF_PHY_RESET_N;
   logic [3:0] SDIF_CORE_RESET_N;
   logic       DONE;
   logic       TIMEOUT_ERR;
   logic [1:0] ERR_IDX;

   coreresetp_sdif_rst_seq #(
      .TIMEOUT     (8),
      .RELEASE_DLY (4)
   ) dut (
      .CLK_BASE          (CLK_BASE),
      .RESET             (RESET),
      .START             (START),
      .SDIF_EN           (SDIF_EN),
      .SDIF_READY        (SDIF_READY),
      .HOT_REQ           (HOT_REQ),
      .SDIF_PHY_RESET_N  (SDIF_PHY_RESET_N),
      .SDIF_CORE_RESET_N (SDIF_CORE_RESET_N),
      .DONE              (DONE),
      .TIMEOUT_ERR       (TIMEOUT_ERR),
      .ERR_IDX           (ERR_IDX)
   );

   initial CLK_BASE = 1'b0;
   always #5 CLK_BASE = ~CLK_BASE;

   int tests = 0;
   int fails = 0;
   int cyc   = 0;
   logic mon_en = 1'b0;
   logic [11:0] last_snap = 12'h000;
   int last_cyc = 0;

   // snapshot layout: {PHY_N[3:0], CORE_N[3:0], DONE, TIMEOUT_ERR, ERR_IDX[1:0]}
   logic [11:0] exp_val[$];
   int          exp_dly[$];
   string       exp_tag[$];

   always @(posedge CLK_BASE) cyc++;

   always @(negedge CLK_BASE) begin : monitor
      logic [11:0] snap;
      logic [11:0] v;
      int          d;
      string       tag;
      snap = {SDIF_PHY_RESET_N, SDIF_CORE_RESET_N, DONE, TIMEOUT_ERR, ERR_IDX};
      if (mon_en && snap !== last_snap) begin
         if (exp_val.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_change got=%b required=%b (no change due)", snap, last_snap);
         end else begin
            v   = exp_val.pop_front();
            d   = exp_dly.pop_front();
            tag = exp_tag.pop_front();
            tests++;
            if (snap !== v) begin
               fails++;
               $display("FAIL %s value got=%b required=%b", tag, snap, v);
            end
            if (d >= 0) begin
               tests++;
               if (cyc - last_cyc != d) begin
                  fails++;
                  $display("FAIL %s delay got=%0d required=%0d", tag, cyc - last_cyc, d);
               end
            end
         end
         last_cyc = cyc;
      end
      last_snap = snap;
   end

   task automatic tick(input int n);
      repeat (n) @(posedge CLK_BASE);
      #1;
   endtask

   task automatic push(input string tag, input logic [3:0] p, input logic [3:0] c,
                       input logic d, input logic t, input logic [1:0] ix, input int dly);
      exp_val.push_back({p, c, d, t, ix});
      exp_dly.push_back(dly);
      exp_tag.push_back(tag);
   endtask

   task automatic pulse_start();
      START = 1'b1;
      tick(1);
      START = 1'b0;
   endtask

   task automatic drain(input string name);
      int n;
      n = 0;
      while (exp_val.size() != 0 && n < 300) begin
         tick(1);
         n++;
      end
      tests++;
      if (exp_val.size() != 0) begin
         fails++;
         $display("FAIL %s_drain pending=%0d required=0", name, exp_val.size());
         exp_val.delete();
         exp_dly.delete();
         exp_tag.delete();
      end
      tick(5);
   endtask

   task automatic check_now(input string name, input logic [11:0] req);
      logic [11:0] snap;
      snap = {SDIF_PHY_RESET_N, SDIF_CORE_RESET_N, DONE, TIMEOUT_ERR, ERR_IDX};
      tests++;
      if (snap !== req) begin
         fails++;
         $display("FAIL %s got=%b required=%b", name, snap, req);
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      RESET      = 1'b1;
      START      = 1'b0;
      SDIF_EN    = 4'b0000;
      SDIF_READY = 4'b0000;
      HOT_REQ    = 4'b0000;
      tick(3);
      check_now("reset_state", 12'h000);
      SDIF_EN    = 4'b0001;
      SDIF_READY = 4'b1111;
      HOT_REQ    = 4'b1111;
      tick(1);
      check_now("reset_ignores_hot", 12'h000);
      HOT_REQ = 4'b0000;
      RESET   = 1'b0;
      mon_en  = 1'b1;
      tick(4);

      // basic single-SDIF release; a second START mid-sequence must be ignored
      push("basic_phy",  4'b0001, 4'b0000, 1'b0, 1'b0, 2'b00, -1);
      push("basic_core", 4'b0001, 4'b0001, 1'b0, 1'b0, 2'b00, 5);
      push("basic_done", 4'b0001, 4'b0001, 1'b1, 1'b0, 2'b00, 7);
      pulse_start();
      tick(4);
      pulse_start();
      drain("basic");

      // SDIF1 never ready -> timeout on index 1
      SDIF_READY = 4'b0001;
      SDIF_EN    = 4'b0011;
      tick(3);
      push("tmo_clear", 4'b0000, 4'b0000, 1'b0, 1'b0, 2'b00, -1);
      push("tmo_phy0",  4'b0001, 4'b0000, 1'b0, 1'b0, 2'b00, 1);
      push("tmo_core0", 4'b0001, 4'b0001, 1'b0, 1'b0, 2'b00, 5);
      push("tmo_phy1",  4'b0011, 4'b0001, 1'b0, 1'b0, 2'b00, 2);
      push("tmo_err",   4'b0011, 4'b0001, 1'b0, 1'b1, 2'b01, 8);
      pulse_start();
      drain("timeout");

      // restart out of the error state
      SDIF_READY = 4'b0011;
      tick(3);
      push("rst_clear", 4'b0000, 4'b0000, 1'b0, 1'b0, 2'b00, -1);
      push("rst_phy0",  4'b0001, 4'b0000, 1'b0, 1'b0, 2'b00, 1);
      push("rst_core0", 4'b0001, 4'b0001, 1'b0, 1'b0, 2'b00, 5);
      push("rst_phy1",  4'b0011, 4'b0001, 1'b0, 1'b0, 2'b00, 2);
      push("rst_core1", 4'b0011, 4'b0011, 1'b0, 1'b0, 2'b00, 5);
      push("rst_done",  4'b0011, 4'b0011, 1'b1, 1'b0, 2'b00, 5);
      pulse_start();
      drain("restart");

      // all four SDIFs with START held high, then hot reset on SDIF2
      SDIF_EN    = 4'b1111;
      SDIF_READY = 4'b1111;
      tick(3);
      push("all_clear", 4'b0000, 4'b0000, 1'b0, 1'b0, 2'b00, -1);
      push("all_phy0",  4'b0001, 4'b0000, 1'b0, 1'b0, 2'b00, 1);
      push("all_core0", 4'b0001, 4'b0001, 1'b0, 1'b0, 2'b00, 5);
      push("all_phy1",  4'b0011, 4'b0001, 1'b0, 1'b0, 2'b00, 2);
      push("all_core1", 4'b0011, 4'b0011, 1'b0, 1'b0, 2'b00, 5);
      push("all_phy2",  4'b0111, 4'b0011, 1'b0, 1'b0, 2'b00, 2);
      push("all_core2", 4'b0111, 4'b0111, 1'b0, 1'b0, 2'b00, 5);
      push("all_phy3",  4'b1111, 4'b0111, 1'b0, 1'b0, 2'b00, 2);
      push("all_core3", 4'b1111, 4'b1111, 1'b0, 1'b0, 2'b00, 5);
      push("all_done",  4'b1111, 4'b1111, 1'b1, 1'b0, 2'b00, 1);
      START = 1'b1;
      drain("all");
      push("hot_assert",  4'b1111, 4'b1011, 1'b1, 1'b0, 2'b00, -1);
      push("hot_release", 4'b1111, 4'b1111, 1'b1, 1'b0, 2'b00, 3);
      HOT_REQ = 4'b0100;
      tick(3);
      HOT_REQ = 4'b0000;
      drain("hot");
      START = 1'b0;
      tick(3);

      // SDIF0 ready drops during CORE_DLY and returns within the timeout window
      SDIF_EN = 4'b0001;
      tick(2);
      push("drop_clear", 4'b0000, 4'b0000, 1'b0, 1'b0, 2'b00, -1);
      push("drop_phy",   4'b0001, 4'b0000, 1'b0, 1'b0, 2'b00, 1);
      push("drop_core",  4'b0001, 4'b0001, 1'b0, 1'b0, 2'b00, 11);
      push("drop_done",  4'b0001, 4'b0001, 1'b1, 1'b0, 2'b00, 7);
      pulse_start();
      tick(1);
      SDIF_READY = 4'b1110;
      tick(4);
      SDIF_READY = 4'b1111;
      drain("drop");

      // asynchronous reset mid-CORE_DLY, START held high across release
      push("ar_clear", 4'b0000, 4'b0000, 1'b0, 1'b0, 2'b00, -1);
      push("ar_phy",   4'b0001, 4'b0000, 1'b0, 1'b0, 2'b00, 1);
      push("ar_reset", 4'b0000, 4'b0000, 1'b0, 1'b0, 2'b00, -1);
      pulse_start();
      tick(3);
      RESET = 1'b1;
      START = 1'b1;
      #1;
      check_now("async_reset_no_edge", 12'h000);
      tick(2);
      RESET = 1'b0;
      tick(30);
      drain("async_reset");
      check_now("no_start_after_reset", 12'h000);
      START = 1'b0;
      tick(2);
      push("post_phy",  4'b0001, 4'b0000, 1'b0, 1'b0, 2'b00, -1);
      push("post_core", 4'b0001, 4'b0001, 1'b0, 1'b0, 2'b00, 5);
      push("post_done", 4'b0001, 4'b0001, 1'b1, 1'b0, 2'b00, 7);
      pulse_start();
      drain("post_reset");

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/coreresetp_sdif_rst_seq.md
CORERESETP_SDIF_RST_SEQ -- requirements
Module: coreresetp_sdif_rst_seq

Interface
REQ-001 Parameter TIMEOUT, default 1000: WAIT_READY limit in CLK_BASE cycles; legal range 1..65535.
REQ-002 Parameter RELEASE_DLY, default 16: cycles from SDIF ready to core reset release; legal range 1..65535.
REQ-003 CLK_BASE  in  1  sole clock; all flops are clocked on its rising edge.
REQ-004 RESET  in  1  asynchronous, active-high reset.
REQ-005 START  in  1  sequence request; only its rising edge (START=1 while previous sample=0) acts.
REQ-006 SDIF_EN  in  4  per-SDIF present mask; static while a sequence runs.
REQ-007 SDIF_READY  in  4  per-SDIF ready (PLL lock/PHY ready); asynchronous to CLK_BASE.
REQ-008 HOT_REQ  in  4  per-SDIF active-high core reset request from the hot-reset logic.
REQ-009 SDIF_PHY_RESET_N  out  4  per-SDIF PHY reset, active-low.
REQ-010 SDIF_CORE_RESET_N  out  4  per-SDIF core reset, active-low.
REQ-011 DONE  out  1  all enabled SDIFs released.
REQ-012 TIMEOUT_ERR  out  1  ready wait expired.
REQ-013 ERR_IDX  out  2  index of the SDIF that timed out.

Function
REQ-014 SDIF_READY shall pass through a 2-flop synchronizer (ready_s) before use; the FSM sees a pin change 2 cycles later.
REQ-015 Registers: FSM state, idx[1:0], cnt[15:0], phy_rel[3:0], core_rel[3:0], start_q. All outputs shall be registered.
REQ-016 IDLE: on START edge, go to SEL with idx=0 and cnt=0.
REQ-017 SEL: if SDIF_EN[idx]=0, go to NEXT; else set phy_rel[idx]=1, clear cnt, go to WAIT_READY.
REQ-018 WAIT_READY, ready_s[idx]=1: clear cnt, go to CORE_DLY.
REQ-019 WAIT_READY, ready_s[idx]=0 and cnt=TIMEOUT-1: go to ERR; otherwise increment cnt.
REQ-020 CORE_DLY, ready_s[idx]=0: clear cnt, return to WAIT_READY; the timeout restarts from 0.
REQ-021 CORE_DLY, ready_s[idx]=1: when cnt=RELEASE_DLY-1, set core_rel[idx]=1 and go to NEXT; otherwise increment cnt.
REQ-022 NEXT: if idx=3, go to DONE_ST; else increment idx and go to SEL.
REQ-023 DONE_ST: DONE=1; SDIF_READY is ignored.
REQ-024 ERR: TIMEOUT_ERR=1 and ERR_IDX=idx, held; phy_rel and core_rel are held as they were.
REQ-025 START edge in DONE_ST or ERR shall, on the same clock edge, clear phy_rel, core_rel, DONE, TIMEOUT_ERR and ERR_IDX, set idx=0, and go to SEL.
REQ-026 START edge in SEL, WAIT_READY, CORE_DLY or NEXT shall be ignored.
REQ-027 START held high shall produce exactly one sequence.
REQ-028 SDIF_PHY_RESET_N = phy_rel, registered.
REQ-029 SDIF_CORE_RESET_N[i] = core_rel[i] AND NOT HOT_REQ[i], registered (1-cycle latency).
REQ-030 HOT_REQ shall act in every state and shall never affect phy_rel, core_rel or the FSM.
REQ-031 With ready already high, SDIF_CORE_RESET_N[i] shall rise RELEASE_DLY+1 cycles after SDIF_PHY_RESET_N[i].
REQ-032 A disabled SDIF shall cost 2 cycles (SEL, NEXT), and its outputs shall stay 0.
REQ-033 cnt shall never wrap, because compares terminate it at or below 65534.

Reset
REQ-034 RESET=1 shall immediately force the following: state=IDLE, idx=0, cnt=0, phy_rel=0, core_rel=0, start_q=0, synchronizer flops=0.
REQ-035 RESET=1 shall immediately force the following outputs: SDIF_PHY_RESET_N=4'b0000, SDIF_CORE_RESET_N=4'b0000, DONE=0, TIMEOUT_ERR=0, ERR_IDX=2'b00.
REQ-036 RESET asserted mid-sequence shall abort the sequence with no completion.
REQ-037 After RESET deasserts, a new START edge is required to begin a sequence.

Verification (TIMEOUT=8, RELEASE_DLY=4)
REQ-038 Basic: SDIF_EN=0001, SDIF_READY=1111 stable, START pulse -> PHY_N=0001, then CORE_N=0001 exactly 5 cycles later, then DONE=1; bits 3:1 stay 0.
REQ-039 Timeout: SDIF_EN=0011, SDIF_READY=0001, START pulse -> SDIF0 fully released, PHY_N=0011; 8 cycles in WAIT_READY, then TIMEOUT_ERR=1, ERR_IDX=01, CORE_N=0001, DONE=0.
REQ-040 Restart: from the timeout state, raise SDIF_READY[1], then START edge -> all outputs 0 for one cycle, resequence, DONE=1, CORE_N=0011, TIMEOUT_ERR=0.
REQ-041 Hot reset: in DONE with CORE_N=1111, HOT_REQ=0100 for 3 cycles -> CORE_N=1011 one cycle later for 3 cycles, then 1111; PHY_N and DONE unchanged.
REQ-042 Ready drop: SDIF_READY[0] falls during CORE_DLY -> CORE_N[0] stays 0; FSM returns to WAIT_READY; ready restored within 8 cycles -> release completes with no error.
REQ-043 Async reset: RESET pulse mid-CORE_DLY -> all outputs 0 without a clock edge; START held high with no edge afterwards -> no sequence starts.
